// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused LSB first, valid/ready on both sides.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (A-B computed as A+~B+1).
//
// state   | meaning
// S_IDLE  | waiting for operands, start_ready high
// S_SHIFT | one bit per cycle through the slice, WIDTH cycles
// S_DONE  | publish result registers, then hold done_valid until done_ready
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] sum_q;
   logic             cflop;
   logic             carry_q;
   logic             done_valid_q;
   logic [CW-1:0]    cnt;
   logic             p, g0, g1, sbit, cout;
   logic             sub_l;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_l = sub;
`else
   assign sub_l = 1'b0;
`endif

   half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(p),    .c(g0));
   half_adder u_ha1 (.x(p),       .y(cflop),   .s(sbit), .c(g1));
   assign cout = g0 | g1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         a_sr         <= '0;
         b_sr         <= '0;
         s_sr         <= '0;
         sum_q        <= '0;
         cflop        <= 1'b0;
         carry_q      <= 1'b0;
         done_valid_q <= 1'b0;
         cnt          <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_sr  <= a;
                  b_sr  <= sub_l ? ~b : b;
                  cflop <= sub_l;
                  s_sr  <= '0;
                  cnt   <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= {sbit, s_sr[WIDTH-1:1]};
               cflop <= cout;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1))
                  state <= S_DONE;
            end
            S_DONE: begin
               // first DONE cycle copies the finished shift register to the outputs
               if (!done_valid_q) begin
                  done_valid_q <= 1'b1;
                  sum_q        <= s_sr;
                  carry_q      <= cflop;
               end else if (done_ready) begin
                  done_valid_q <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign start_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign done_valid  = done_valid_q;
   assign sum         = sum_q;
   assign carry       = carry_q;

endmodule

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): reset, adds, backpressure, mid-op reset, sweep.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_valid = 1'b0;
   logic       done_ready = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       start_ready;
   logic       done_valid;
   logic [7:0] sum;
   logic       carry;
   logic       busy;
`ifdef SERIAL_ADD_SUB_EN
   logic       sub = 1'b0;
`endif

   int n_checks = 0;
   int n_fail = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
`ifdef SERIAL_ADD_SUB_EN
      .sub         (sub),
`endif
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .sum         (sum),
      .carry       (carry),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // one full transaction with done_ready high; lat counts edges from accept to done_valid
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         output logic [7:0] osum, output logic ocar, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!start_ready && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (start_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL op_ready: start_ready=%b required 1", start_ready);
      end
      a = ia; b = ib; start_valid = 1'b1; done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0; a = ~ia; b = ~ib;
      lat = 0;
      while (done_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      osum = sum; ocar = carry;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL rst_start_ready: got %b required 1", start_ready); end
      n_checks++; if (done_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_done_valid: got %b required 0", done_valid); end
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      n_checks++; if (sum !== 8'h00)        begin n_fail++; $display("FAIL rst_sum: got %h required 00", sum); end
      n_checks++; if (carry !== 1'b0)       begin n_fail++; $display("FAIL rst_carry: got %b required 0", carry); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      logic [7:0] va [7] = '{8'h35, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h55, 8'h7F};
      logic [7:0] vb [7] = '{8'h0A, 8'h01, 8'hFF, 8'h00, 8'h80, 8'hAA, 8'h01};
      logic [7:0] vs [7] = '{8'h3F, 8'h00, 8'hFE, 8'h00, 8'h00, 8'hFF, 8'h80};
      logic       vc [7] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
      logic [7:0] rs;
      logic       rc;
      int         lat;
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], rs, rc, lat);
         n_checks++;
         if (lat !== 9) begin n_fail++; $display("FAIL add_latency %h+%h: got %0d required 9", va[i], vb[i], lat); end
         n_checks++;
         if (rs !== vs[i]) begin n_fail++; $display("FAIL add_sum %h+%h: got %h required %h", va[i], vb[i], rs, vs[i]); end
         n_checks++;
         if (rc !== vc[i]) begin n_fail++; $display("FAIL add_carry %h+%h: got %b required %b", va[i], vb[i], rc, vc[i]); end
      end
   endtask

   task automatic test_backpressure();
      int lat = 0;
      int guard = 0;
      @(negedge clk);
      a = 8'h12; b = 8'h34; start_valid = 1'b1; done_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      while (done_valid !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_checks++; if (sum !== 8'h46) begin n_fail++; $display("FAIL bp_first_sum: got %h required 46", sum); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL bp_first_carry: got %b required 0", carry); end
      a = 8'hF0; b = 8'h0F; start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_checks++; if (done_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b required 1", i, done_valid); end
         n_checks++; if (sum !== 8'h46)        begin n_fail++; $display("FAIL bp_hold_sum c%0d: got %h required 46", i, sum); end
         n_checks++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready c%0d: got %b required 0", i, start_ready); end
         n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL bp_hold_busy c%0d: got %b required 1", i, busy); end
      end
      done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_ready = 1'b0;
      n_checks++; if (done_valid !== 1'b0)  begin n_fail++; $display("FAIL bp_release_valid: got %b required 0", done_valid); end
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", start_ready); end
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0; done_ready = 1'b1;
      while (done_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      n_checks++; if (lat !== 9)      begin n_fail++; $display("FAIL bp_second_latency: got %0d required 9", lat); end
      n_checks++; if (sum !== 8'hFF)  begin n_fail++; $display("FAIL bp_second_sum: got %h required FF", sum); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL bp_second_carry: got %b required 0", carry); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0] rs;
      logic       rc;
      int         lat;
      int         seen_valid = 0;
      @(negedge clk);
      a = 8'hC3; b = 8'h3C; start_valid = 1'b1; done_ready = 1'b1;
      @(posedge clk);
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_start_ready: got %b required 1", start_ready); end
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy); end
      n_checks++; if (done_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid_done_valid: got %b required 0", done_valid); end
      n_checks++; if (sum !== 8'h00)        begin n_fail++; $display("FAIL rmid_sum: got %h required 00", sum); end
      n_checks++; if (carry !== 1'b0)       begin n_fail++; $display("FAIL rmid_carry: got %b required 0", carry); end
      a = 8'h01; b = 8'h01; start_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_accept: busy=%b required 0", busy); end
      rst_n = 1'b1; start_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_valid === 1'b1) seen_valid++;
      end
      n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL rmid_no_result: done_valid high %0d cycles required 0", seen_valid); end
      run_op(8'h10, 8'h20, rs, rc, lat);
      n_checks++; if (rs !== 8'h30) begin n_fail++; $display("FAIL rmid_after_sum: got %h required 30", rs); end
      n_checks++; if (rc !== 1'b0)  begin n_fail++; $display("FAIL rmid_after_carry: got %b required 0", rc); end
      n_checks++; if (lat !== 9)    begin n_fail++; $display("FAIL rmid_after_latency: got %0d required 9", lat); end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      logic [7:0] rs;
      logic       rc;
      int         lat;
      sub = 1'b1;
      run_op(8'h05, 8'h07, rs, rc, lat);
      n_checks++; if (rs !== 8'hFE) begin n_fail++; $display("FAIL sub_5m7_sum: got %h required FE", rs); end
      n_checks++; if (rc !== 1'b0)  begin n_fail++; $display("FAIL sub_5m7_carry: got %b required 0", rc); end
      n_checks++; if (lat !== 9)    begin n_fail++; $display("FAIL sub_latency: got %0d required 9", lat); end
      run_op(8'h07, 8'h05, rs, rc, lat);
      n_checks++; if (rs !== 8'h02) begin n_fail++; $display("FAIL sub_7m5_sum: got %h required 02", rs); end
      n_checks++; if (rc !== 1'b1)  begin n_fail++; $display("FAIL sub_7m5_carry: got %b required 1", rc); end
      sub = 1'b0;
   endtask
`endif

   task automatic test_sweep();
      logic [7:0] rs;
      logic       rc;
      logic [8:0] ref_v;
      int         lat;
      for (int ai = 0; ai < 256; ai += 17) begin
         for (int bi = 0; bi < 256; bi += 17) begin
            ref_v = 9'(ai) + 9'(bi);
            run_op(8'(ai), 8'(bi), rs, rc, lat);
            n_checks++;
            if ({rc, rs} !== ref_v) begin
               n_fail++;
               $display("FAIL sweep %h+%h: got %b_%h required %b_%h", ai[7:0], bi[7:0], rc, rs, ref_v[8], ref_v[7:0]);
            end
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL sweep_latency %h+%h: got %0d required 9", ai[7:0], bi[7:0], lat); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_backpressure();
      test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
